// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH product, one partial product per clock.
// Latency: accept at edge N -> out_valid high after edge N+WIDTH+1 (WIDTH add cycles + 1 transfer cycle).
// Backpressure: in_ready only in IDLE; product held stable in DONE until out_ready.
//
// Ports: clk/rst_n (async active-low), in_valid/in_ready/a/b operand handshake,
//        out_valid/out_ready/p product handshake, busy = CALC or DONE,
//        is_signed (only when SEQ_MULT_SIGNED_EN is defined) selects two's-complement operands.
// Optional macro: SEQ_MULT_SIGNED_EN adds the is_signed port and sign/magnitude handling.
module seq_shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
`ifdef SEQ_MULT_SIGNED_EN
    ,
    input  logic               is_signed
`endif
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0]      LAST_CNT = CW'(WIDTH);
    localparam logic [CW-1:0]      ONE_C    = CW'(1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] mcand;    // multiplicand, pre-shifted by cnt
    logic [WIDTH-1:0]   mplier;   // multiplier, shifted right so bit[cnt] sits at bit 0
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] p_q;

    logic [WIDTH-1:0]   a_ld;
    logic [WIDTH-1:0]   b_ld;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] result;

`ifdef SEQ_MULT_SIGNED_EN
    localparam logic [WIDTH-1:0]   ONE_W = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_P = (2*WIDTH)'(1);

    logic sign_q;
    logic neg_a;
    logic neg_b;

    // Magnitudes fit in WIDTH unsigned bits: -2^(WIDTH-1) negates to 2^(WIDTH-1) exactly.
    always_comb begin
        neg_a  = is_signed & a[WIDTH-1];
        neg_b  = is_signed & b[WIDTH-1];
        a_ld   = neg_a ? (~a + ONE_W) : a;
        b_ld   = neg_b ? (~b + ONE_W) : b;
        result = sign_q ? (~acc + ONE_P) : acc;
    end
`else
    always_comb begin
        a_ld   = a;
        b_ld   = b;
        result = acc;
    end
`endif

    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            p_q    <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        mcand  <= {{WIDTH{1'b0}}, a_ld};
                        mplier <= b_ld;
                        acc    <= '0;
                        cnt    <= '0;
`ifdef SEQ_MULT_SIGNED_EN
                        sign_q <= neg_a ^ neg_b;
`endif
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    // cnt reaches WIDTH only after every multiplier bit has been added,
                    // so this cycle just moves the (optionally negated) sum into p.
                    if (cnt == LAST_CNT) begin
                        p_q   <= result;
                        state <= S_DONE;
                    end else begin
                        acc    <= acc_next;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + ONE_C;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Handshake outputs decode straight from state so an async reset updates them immediately.
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign p         = p_q;

endmodule
